cntry_car_detector: RTL and testbench
=====================================

// Module: cntry_car_detector
// PURPOSE
//  Front end for the country-road vehicle loop. Synchronises and debounces the
//  raw loop sensor, counts waiting cars and produces the X request that the
//  highway/country signal controller consumes.
//  X stays high while at least one counted car has not yet departed on green.
// PARAMETERS
//  DEB_CYCLES    16    cycles loop_s must be stable to qualify a car arrival or release
//  CNT_W         4     width of the waiting-car counter; saturates at 2**CNT_W-1
//  STUCK_CYCLES  1024  cycles in OCCUPIED before a stuck-loop fault (STUCK_DETECT_EN only)
// PORTS
//  clock         in   1      system clock; all state changes on its rising edge
//  clear_n       in   1      asynchronous active-low reset
//  loop_raw      in   1      raw loop sensor, asynchronous to clock; 1 = metal present
//  depart_pulse  in   1      1-cycle pulse from the stop-line exit sensor (synchronous)
//  cntry_green   in   1      1 while the controller drives the country light GREEN
//  X             out  1      car waiting on country road; equals (car_count != 0)
//  car_count     out  CNT_W  number of cars waiting
//  overflow      out  1      sticky; set when an arrival is lost to counter saturation
//  sensor_fault  out  1      sticky stuck-loop flag (tied 0 without STUCK_DETECT_EN)
// BEHAVIOUR
//  Reset (clear_n=0, any time, mid-qualify included):
//  - state=IDLE, deb_cnt=0, sync flops=0, car_count=0, X=0, overflow=0, sensor_fault=0.
//  Sync: loop_raw passes through a 2-flop synchroniser to give loop_s; nothing else
//  samples loop_raw.
//  FSM (deb_cnt cleared on every state change):
//  - IDLE:     loop_s=1 -> QUAL.
//  - QUAL:     loop_s=0 -> IDLE (glitch, no count).
//              deb_cnt==DEB_CYCLES-1 with loop_s=1 -> OCCUPIED and generate arrival.
//              Otherwise deb_cnt++.
//  - OCCUPIED: loop_s=0 -> RELEASE.
//  - RELEASE:  loop_s=1 -> OCCUPIED (no new arrival).
//              deb_cnt==DEB_CYCLES-1 with loop_s=0 -> IDLE.
//              Otherwise deb_cnt++.
//  Latency: loop_raw held high from edge 1 -> X rises right after edge DEB_CYCLES+3.
//  Counter, evaluated on each edge:
//  - dep = depart_pulse & cntry_green & (car_count!=0).
//  - arrival & dep together -> count unchanged.
//  - arrival only -> +1, saturating. At max the count holds and overflow is set.
//  - dep only -> -1.
//  - depart_pulse while not green, or while count is 0 -> ignored, no error.
//  X is combinational from the car_count register; no other logic feeds X.
// CONFIGURATION
//  STUCK_DETECT_EN defined:
//  - A counter runs in OCCUPIED and clears on leaving OCCUPIED.
//  - On reaching STUCK_CYCLES: sensor_fault=1 (sticky) and car_count forced to at
//    least 1, so X stays high and the country road is still served (fail-safe).
//  - The fault clears only on reset.
//  STUCK_DETECT_EN undefined: no stuck counter; sensor_fault is constant 0.
// TESTING  (DEB_CYCLES=4, CNT_W=2, STUCK_CYCLES=32)
//  - Reset: pulse clear_n low asynchronously mid-QUAL -> all outputs 0 immediately.
//    FSM is in IDLE after release.
//  - loop_raw high from edge 1, held -> X=0 through edge 6; X=1, car_count=1 after edge 7.
//  - loop_raw high for 3 cycles then low -> no arrival; car_count stays 0; X stays 0.
//  - 3 cars qualified, then 2 depart_pulse with cntry_green=1 -> count 3,2,1; X stays 1.
//    Further depart_pulse with cntry_green=0 -> count stays 1.
//  - Arrival and qualifying depart_pulse on the same edge (count 2) -> count stays 2.
//    4th arrival at count 3 -> count 3, overflow=1.
//  - STUCK_DETECT_EN: loop held high 40 cycles -> sensor_fault=1 and X=1.
//    Departures that reduce the count toward 0 keep it at >=1 while fault is set.

Source files
------------

// File: rtl/cntry_car_detector.sv
// Country-road loop front end: synchronises and debounces the loop sensor, counts waiting cars, drives X.
// Optional stuck-loop detection is enabled by defining STUCK_DETECT_EN.
module cntry_car_detector #(
    parameter int DEB_CYCLES   = 16,
    parameter int CNT_W        = 4,
    parameter int STUCK_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             loop_raw,
    input  logic             depart_pulse,
    input  logic             cntry_green,
    output logic             X,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow,
    output logic             sensor_fault
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, QUAL, OCCUPIED, RELEASE} state_t;

    state_t           state;
    logic [DEB_W-1:0] deb_cnt;
    logic             sync1;
    logic             loop_s;
    logic             arrival;
    logic             dep;
    logic             ovf_set;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync1  <= 1'b0;
            loop_s <= 1'b0;
        end else begin
            sync1  <= loop_raw;
            loop_s <= sync1;
        end
    end

    // Debounce FSM; the arrival fires on the same edge that enters OCCUPIED.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= IDLE;
            deb_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (loop_s) state <= QUAL;
                    deb_cnt <= '0;
                end
                QUAL: begin
                    if (!loop_s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= OCCUPIED;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                OCCUPIED: begin
                    if (!loop_s) state <= RELEASE;
                    deb_cnt <= '0;
                end
                RELEASE: begin
                    if (loop_s) begin
                        state   <= OCCUPIED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

    assign arrival = (state == QUAL) && loop_s && (deb_cnt == DEB_LAST);
    assign dep     = depart_pulse && cntry_green && (car_count != '0);

`ifdef STUCK_DETECT_EN
    localparam int ST_W = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
    localparam logic [ST_W-1:0] STUCK_LAST = ST_W'(STUCK_CYCLES - 1);

    logic [ST_W-1:0] stuck_cnt;
    logic            stuck_hit;

    assign stuck_hit = (state == OCCUPIED) && (stuck_cnt == STUCK_LAST);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            stuck_cnt    <= '0;
            sensor_fault <= 1'b0;
        end else if (state == OCCUPIED) begin
            if (stuck_hit) sensor_fault <= 1'b1;
            else           stuck_cnt    <= stuck_cnt + 1'b1;
        end else begin
            stuck_cnt <= '0;
        end
    end
`else
    assign sensor_fault = 1'b0;
`endif

    // A simultaneous arrival and departure cancel; a lost arrival at saturation sets overflow.
    always_comb begin
        count_next = car_count;
        ovf_set    = 1'b0;
        if (arrival && !dep) begin
            if (car_count == CNT_MAX) ovf_set    = 1'b1;
            else                      count_next = car_count + 1'b1;
        end else if (dep && !arrival) begin
            count_next = car_count - 1'b1;
        end
`ifdef STUCK_DETECT_EN
        if ((sensor_fault || stuck_hit) && (count_next == '0))
            count_next = CNT_W'(1);
`endif
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            car_count <= '0;
            overflow  <= 1'b0;
        end else begin
            car_count <= count_next;
            if (ovf_set) overflow <= 1'b1;
        end
    end

    assign X = (car_count != '0);

endmodule

// File: tb/tb_cntry_car_detector.sv
// Self-checking bench for cntry_car_detector: directed scenarios plus random loop activity
// compared against a run-length reference model of the debounce and car counting rules.
module tb_cntry_car_detector;

    localparam int DEB   = 4;
    localparam int CW    = 2;
    localparam int STUCK = 32;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          loop_raw = 1'b0;
    logic          depart_pulse = 1'b0;
    logic          cntry_green = 1'b0;
    logic          X;
    logic [CW-1:0] car_count;
    logic          overflow;
    logic          sensor_fault;

    int passed = 0;
    int total  = 0;

    // Reference model state: synchroniser samples, run lengths of loop_s, occupancy, counters.
    logic m_s1, m_s2, m_last;
    int   hi_run, lo_run, stuck_run, m_cnt;
    bit   m_occ, m_ovf, m_fault;

    cntry_car_detector #(.DEB_CYCLES(DEB), .CNT_W(CW), .STUCK_CYCLES(STUCK)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .loop_raw     (loop_raw),
        .depart_pulse (depart_pulse),
        .cntry_green  (cntry_green),
        .X            (X),
        .car_count    (car_count),
        .overflow     (overflow),
        .sensor_fault (sensor_fault)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_last = 0;
        hi_run = 0; lo_run = 0; stuck_run = 0; m_cnt = 0;
        m_occ = 0; m_ovf = 0; m_fault = 0;
    endtask

    task automatic model_edge(input logic raw, input logic dp, input logic gr);
        logic ls;
        bit   arr, dep, in_occ_pre;
        ls = m_s2;
        arr = 0;
        in_occ_pre = m_occ && m_last;
        if (ls) begin hi_run++; lo_run = 0; end
        else    begin lo_run++; hi_run = 0; end
        if (!m_occ && hi_run == DEB + 1) begin arr = 1; m_occ = 1; end
        else if (m_occ && lo_run == DEB + 1) m_occ = 0;
`ifdef STUCK_DETECT_EN
        if (in_occ_pre) stuck_run++;
        else            stuck_run = 0;
        if (stuck_run >= STUCK) m_fault = 1;
`endif
        dep = dp && gr && (m_cnt != 0);
        if (arr && !dep) begin
            if (m_cnt == CMAX) m_ovf = 1;
            else               m_cnt++;
        end else if (dep && !arr) begin
            m_cnt--;
        end
        if (m_fault && m_cnt == 0) m_cnt = 1;
        m_last = ls;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_model();
        checkOutput("car_count", 8'(car_count), 8'(m_cnt));
        checkOutput("x", 8'(X), 8'(m_cnt != 0));
        checkOutput("overflow", 8'(overflow), 8'(m_ovf));
        checkOutput("sensor_fault", 8'(sensor_fault), 8'(m_fault));
    endtask

    task automatic applyStimulus(input logic raw, input logic dp, input logic gr);
        loop_raw = raw; depart_pulse = dp; cntry_green = gr;
        @(posedge clock);
        model_edge(raw, dp, gr);
        #1;
        check_model();
    endtask

    task automatic car();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_n = 1'b0;
        model_reset();
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    initial begin
        model_reset();
        loop_raw = 0; depart_pulse = 0; cntry_green = 0;
        #1;
        checkOutput("reset_count", 8'(car_count), 8'd0);
        checkOutput("reset_x", 8'(X), 8'd0);
        @(negedge clock);
        @(negedge clock);
        clear_n = 1'b1;

        // Count one car, then get part way through qualifying a second and reset asynchronously.
        car();
        checkOutput("first_car", 8'(car_count), 8'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        #2;
        clear_n = 1'b0;
        #1;
        model_reset();
        checkOutput("async_rst_count", 8'(car_count), 8'd0);
        checkOutput("async_rst_x", 8'(X), 8'd0);
        checkOutput("async_rst_ovf", 8'(overflow), 8'd0);
        loop_raw = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;

        // Latency: loop held from edge 1, X rises right after edge DEB+3.
        for (int e = 1; e <= DEB + 2; e++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("latency_x_low", 8'(X), 8'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("latency_x_high", 8'(X), 8'd1);
        checkOutput("latency_count", 8'(car_count), 8'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Short pulse is a glitch and is not counted.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("glitch_count", 8'(car_count), 8'd1);

        do_reset();
        car(); car(); car();
        checkOutput("three_cars", 8'(car_count), 8'd3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("depart_1", 8'(car_count), 8'd2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("depart_2", 8'(car_count), 8'd1);
        checkOutput("depart_x", 8'(X), 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("depart_not_green", 8'(car_count), 8'd1);

        // Bring count to 2, then an arrival and a qualifying departure on the same edge.
        car();
        checkOutput("count_two", 8'(car_count), 8'd2);
        for (int i = 0; i < DEB + 2; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("arr_dep_same_edge", 8'(car_count), 8'd2);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        car();
        checkOutput("count_sat", 8'(car_count), 8'd3);
        checkOutput("no_ovf_yet", 8'(overflow), 8'd0);
        car();
        checkOutput("ovf_count", 8'(car_count), 8'd3);
        checkOutput("ovf_set", 8'(overflow), 8'd1);

        // Random loop activity in held runs, with random departures.
        do_reset();
        for (int r = 0; r < 120; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++)
                applyStimulus(lvl, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        // Loop stuck high for a long time, then drain with departures.
        do_reset();
        for (int i = 0; i < 45; i++) applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef STUCK_DETECT_EN
        checkOutput("stuck_fault", 8'(sensor_fault), 8'd1);
        checkOutput("stuck_x", 8'(X), 8'd1);
`else
        checkOutput("no_stuck_fault", 8'(sensor_fault), 8'd0);
`endif
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
`ifdef STUCK_DETECT_EN
        checkOutput("stuck_keep_one", 8'(car_count), 8'd1);
`else
        checkOutput("stuck_drained", 8'(car_count), 8'd0);
`endif

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
